vx_stream_coalesce: RTL and testbench
=====================================

VX_STREAM_COALESCE -- requirements
Module: VX_stream_coalesce

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of request lanes (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, per-lane payload width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, per-lane tag width.
REQ-004 SHALL have parameter TAG_SEL_BITS, default 2, tag LSBs compared for batch membership (1..TAG_WIDTH).
REQ-005 SHALL have parameter TIMEOUT, default 4, max FILL cycles before forced issue (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port valid_in, input, NUM_REQS, per-lane request valid.
REQ-009 SHALL have port data_in, input, NUM_REQS*DATA_WIDTH, per-lane payload.
REQ-010 SHALL have port tag_in, input, NUM_REQS*TAG_WIDTH, per-lane tag.
REQ-011 SHALL have port ready_in, output, NUM_REQS, per-lane accept.
REQ-012 SHALL have ports valid_out (1), mask_out (NUM_REQS), data_out (NUM_REQS*DATA_WIDTH), tag_out (TAG_WIDTH) as outputs: issued batch.
REQ-013 SHALL have port ready_out, input, 1, downstream accept.

Function
REQ-014 SHALL implement states IDLE, FILL, ISSUE; lane i transfers when valid_in[i] & ready_in[i].
REQ-015 IDLE: batch tag = tag_in of lowest-index valid lane (combinational); ready_in[i] = valid_in[i] & tag LSB match to that tag.
REQ-016 IDLE with any valid_in: capture accepted lanes' data into slots, set mask bits, register batch tag, timer=0; go ISSUE if mask becomes all-ones, else FILL.
REQ-017 FILL: ready_in[i] = ~mask[i] & (tag_in[i][TAG_SEL_BITS-1:0] == batch tag LSBs); accepted lanes captured, mask bits set.
REQ-018 FILL: timer increments by 1 each cycle; width $clog2(TIMEOUT+1); no wrap (saturates irrelevant since exit at TIMEOUT-1).
REQ-019 FILL -> ISSUE when any of: mask (after this cycle's accepts) all-ones; timer == TIMEOUT-1; any valid_in[i] not accepted this cycle (tag mismatch or occupied slot = conflict flush).
REQ-020 Lanes accepted in the exit cycle SHALL be included in the issued batch.
REQ-021 ISSUE: valid_out=1, mask_out=mask, tag_out=batch tag (full TAG_WIDTH from first accepted lane), data_out=slots; ready_in all 0.
REQ-022 ISSUE with ready_out=1: clear mask, go IDLE; outputs stable while ready_out=0.
REQ-023 data_out lanes with mask_out[i]=0 SHALL be zero.
REQ-024 valid_out SHALL be 0 in IDLE and FILL; no combinational path from valid_in to valid_out or from ready_out to ready_in.
REQ-025 Minimum latency: first accept at cycle N -> valid_out at N+1.
REQ-026 Throughput: at most one batch per two cycles (IDLE required between batches).

Reset
REQ-027 On reset: state IDLE, mask 0, timer 0, batch tag 0, slots 0; valid_out 0, mask_out 0, tag_out 0, data_out 0, ready_in 0 during reset cycle.
REQ-028 Reset mid-FILL or mid-ISSUE SHALL discard the partial/pending batch with no output transfer.

Verification (NUM_REQS=4, TIMEOUT=4, TAG_SEL_BITS=2)
REQ-029 All 4 lanes valid, tag 0x11, ready_out=1 -> ready_in=4'b1111 at cycle 0; valid_out=1, mask_out=4'b1111, tag_out=0x11 at cycle 1; IDLE at cycle 2.
REQ-030 Lane0 tag 0x05 at cycle 0, lane2 tag 0x09 (LSBs match) at cycle 2, no others -> mask_out=4'b0101 with valid_out at cycle 4 (timeout), tag_out=0x05.
REQ-031 FILL with mask 4'b0001 tag LSB 1; lane1 presents tag LSB 2 -> ready_in[1]=0, ISSUE next cycle with mask_out=4'b0001; lane1 accepted in following IDLE.
REQ-032 ISSUE with ready_out=0 for 3 cycles -> valid_out, mask_out, data_out, tag_out constant; ready_in=0; transfer on 4th cycle.
REQ-033 Lanes 1,3 valid with tags LSB 3 and 0 in IDLE -> only lane1 accepted (ready_in=4'b0010), batch tag from lane1; FILL exits next cycle on lane3 conflict.
REQ-034 Assert reset in FILL with mask 4'b0011 -> next cycle all outputs 0, no valid_out until new requests.

Source files
------------

// File: rtl/vx_stream_coalesce_if.sv
// Handshake bundle for vx_stream_coalesce: per-lane request side and the
// single coalesced batch side.
interface vx_stream_coalesce_if #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 8
);
    logic [NUM_REQS-1:0]            valid_in;
    logic [NUM_REQS*DATA_WIDTH-1:0] data_in;
    logic [NUM_REQS*TAG_WIDTH-1:0]  tag_in;
    logic [NUM_REQS-1:0]            ready_in;

    logic                           valid_out;
    logic [NUM_REQS-1:0]            mask_out;
    logic [NUM_REQS*DATA_WIDTH-1:0] data_out;
    logic [TAG_WIDTH-1:0]           tag_out;
    logic                           ready_out;

    modport master (
        output valid_in, data_in, tag_in, ready_out,
        input  ready_in, valid_out, mask_out, data_out, tag_out
    );

    modport slave (
        input  valid_in, data_in, tag_in, ready_out,
        output ready_in, valid_out, mask_out, data_out, tag_out
    );
endinterface

// File: rtl/vx_stream_coalesce.sv
// Gathers per-lane requests whose tag LSBs match into one batch, issuing it
// when full, on timeout, or when an incoming request cannot join the batch.
module vx_stream_coalesce #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned TAG_SEL_BITS = 2,
    parameter int unsigned TIMEOUT      = 4
) (
    input logic                clk,
    input logic                reset,
    vx_stream_coalesce_if.slave bus
);
    localparam int unsigned TIMER_W    = $clog2(TIMEOUT + 1);
    // Timer starts at 0 on the first FILL cycle, so FILL lasts TIMEOUT-1 cycles.
    localparam int unsigned TIMER_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
    localparam logic [TAG_WIDTH-1:0] SEL_MASK =
        TAG_WIDTH'((64'd1 << TAG_SEL_BITS) - 64'd1);

    typedef enum logic [1:0] {StIdle, StFill, StIssue} state_e;

    state_e                         state_q;
    logic [NUM_REQS-1:0]            mask_q, mask_d;
    logic [NUM_REQS*DATA_WIDTH-1:0] slots_q, slots_d;
    logic [TAG_WIDTH-1:0]           tag_q;
    logic [TIMER_W-1:0]             timer_q;

    logic                           valid_out_q;
    logic [NUM_REQS-1:0]            mask_out_q;
    logic [NUM_REQS*DATA_WIDTH-1:0] data_out_q;
    logic [TAG_WIDTH-1:0]           tag_out_q;

    logic [TAG_WIDTH-1:0] lead_tag, sel_tag, lane_tag;
    logic [NUM_REQS-1:0]  ready, accept;
    logic                 full, conflict, timeout_hit, any_valid;

    // Tag of the lowest-index valid lane seeds a new batch.
    always_comb begin
        lead_tag = '0;
        for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
            if (bus.valid_in[i]) lead_tag = bus.tag_in[i*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    assign sel_tag = (state_q == StIdle) ? lead_tag : tag_q;

    always_comb begin
        ready    = '0;
        lane_tag = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            lane_tag = bus.tag_in[i*TAG_WIDTH +: TAG_WIDTH];
            if (!reset && (((lane_tag ^ sel_tag) & SEL_MASK) == '0)) begin
                case (state_q)
                    StIdle:  ready[i] = bus.valid_in[i];
                    StFill:  ready[i] = ~mask_q[i];
                    default: ready[i] = 1'b0;
                endcase
            end
        end
    end

    assign accept      = bus.valid_in & ready;
    assign mask_d      = mask_q | accept;
    assign full        = &mask_d;
    assign conflict    = |(bus.valid_in & ~ready);
    assign any_valid   = |bus.valid_in;
    assign timeout_hit = (timer_q >= TIMER_W'(TIMER_LAST));

    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (accept[i]) slots_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            slots_q     <= '0;
            tag_q       <= '0;
            timer_q     <= '0;
            valid_out_q <= 1'b0;
            mask_out_q  <= '0;
            data_out_q  <= '0;
            tag_out_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        mask_q  <= mask_d;
                        slots_q <= slots_d;
                        tag_q   <= lead_tag;
                        timer_q <= '0;
                        if (full) begin
                            state_q     <= StIssue;
                            valid_out_q <= 1'b1;
                            mask_out_q  <= mask_d;
                            data_out_q  <= slots_d;
                            tag_out_q   <= lead_tag;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    mask_q  <= mask_d;
                    slots_q <= slots_d;
                    timer_q <= timer_q + 1'b1;
                    if (full || timeout_hit || conflict) begin
                        state_q     <= StIssue;
                        valid_out_q <= 1'b1;
                        mask_out_q  <= mask_d;
                        data_out_q  <= slots_d;
                        tag_out_q   <= tag_q;
                    end
                end
                StIssue: begin
                    // Slots are cleared here so unmasked lanes of the next batch read zero.
                    if (bus.ready_out) begin
                        state_q     <= StIdle;
                        mask_q      <= '0;
                        slots_q     <= '0;
                        valid_out_q <= 1'b0;
                        mask_out_q  <= '0;
                        data_out_q  <= '0;
                        tag_out_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_out_q;
    assign bus.mask_out  = mask_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.tag_out   = tag_out_q;
endmodule

// File: tb/tb_vx_stream_coalesce.sv
// Directed and randomized checks of vx_stream_coalesce against a batch-level
// reference model (collecting batch + issued batch).
module tb_vx_stream_coalesce;
    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 8;
    localparam int unsigned SEL = 2;
    localparam int unsigned TO  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_stream_coalesce_if #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    vx_stream_coalesce #(
        .NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_SEL_BITS(SEL), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] d_lane[N];
    logic [TW-1:0] t_lane[N];

    // Reference model: one batch being collected, one batch being offered.
    bit            m_issue, m_coll;
    logic [N-1:0]  m_omask, m_cmask;
    logic [DW-1:0] m_odata[N], m_cdata[N];
    logic [TW-1:0] m_otag, m_ctag;
    int            m_cycles;

    logic [N-1:0]    obs_ready, obs_mask;
    logic            obs_valid;
    logic [TW-1:0]   obs_tag;
    logic [N*DW-1:0] obs_data, held_data;

    task automatic chk(input string name, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit lsb_eq(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW-1:0] x;
        x = a ^ b;
        return x[SEL-1:0] == '0;
    endfunction

    task automatic model_clear();
        m_issue = 0; m_coll = 0; m_omask = '0; m_cmask = '0;
        m_otag = '0; m_ctag = '0; m_cycles = 0;
        for (int i = 0; i < N; i++) begin m_odata[i] = '0; m_cdata[i] = '0; end
    endtask

    task automatic close_batch();
        m_issue = 1; m_coll = 0;
        m_omask = m_cmask; m_otag = m_ctag;
        for (int i = 0; i < N; i++) m_odata[i] = m_cmask[i] ? m_cdata[i] : '0;
    endtask

    task automatic step(input bit rst, input logic [N-1:0] v, input bit ro);
        logic [N-1:0]    er, acc;
        logic [N*DW-1:0] ed;
        int              lead;
        @(negedge clk);
        reset = rst;
        bus.valid_in = v;
        bus.ready_out = ro;
        for (int i = 0; i < N; i++) begin
            bus.data_in[i*DW +: DW] = d_lane[i];
            bus.tag_in[i*TW +: TW]  = t_lane[i];
        end
        #1;
        lead = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) lead = i;
        er = '0;
        for (int i = 0; i < N; i++) begin
            if (rst || m_issue) er[i] = 0;
            else if (!m_coll) er[i] = v[i] && (lead >= 0) && lsb_eq(t_lane[i], t_lane[lead]);
            else er[i] = !m_cmask[i] && lsb_eq(t_lane[i], m_ctag);
        end
        ed = '0;
        for (int i = 0; i < N; i++) ed[i*DW +: DW] = (m_issue && m_omask[i]) ? m_odata[i] : '0;
        obs_ready = bus.ready_in; obs_valid = bus.valid_out; obs_mask = bus.mask_out;
        obs_tag = bus.tag_out; obs_data = bus.data_out;
        chk("ready_in", {124'd0, obs_ready}, {124'd0, er});
        chk("valid_out", {127'd0, obs_valid}, {127'd0, m_issue});
        chk("mask_out", {124'd0, obs_mask}, {124'd0, m_issue ? m_omask : 4'b0});
        chk("tag_out", {120'd0, obs_tag}, {120'd0, m_issue ? m_otag : 8'h0});
        chk("data_out", obs_data, ed);
        acc = v & er;
        if (rst) model_clear();
        else if (m_issue) begin
            if (ro) begin m_issue = 0; m_omask = '0; end
        end else if (!m_coll) begin
            if (lead >= 0) begin
                m_cmask = acc; m_ctag = t_lane[lead]; m_cycles = 0;
                for (int i = 0; i < N; i++) if (acc[i]) m_cdata[i] = d_lane[i];
                if (&acc) close_batch(); else m_coll = 1;
            end
        end else begin
            m_cmask = m_cmask | acc;
            for (int i = 0; i < N; i++) if (acc[i]) m_cdata[i] = d_lane[i];
            m_cycles++;
            if ((&m_cmask) || (m_cycles >= TO - 1) || ((v & ~acc) != '0)) close_batch();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) step(0, 4'b0000, 1);
    endtask

    task automatic set_tags(input logic [TW-1:0] t);
        for (int i = 0; i < N; i++) begin t_lane[i] = t; d_lane[i] = $urandom; end
    endtask

    initial begin
        reset = 1'b1;
        bus.valid_in = '0; bus.data_in = '0; bus.tag_in = '0; bus.ready_out = 1'b0;
        model_clear();
        set_tags(8'h00);
        repeat (2) @(posedge clk);

        // Full batch in one cycle.
        set_tags(8'h11);
        step(0, 4'b1111, 1);
        chk("r029_ready", {124'd0, obs_ready}, {124'd0, 4'b1111});
        step(0, 4'b0000, 1);
        chk("r029_valid", {127'd0, obs_valid}, 128'd1);
        chk("r029_mask", {124'd0, obs_mask}, {124'd0, 4'b1111});
        chk("r029_tag", {120'd0, obs_tag}, {120'd0, 8'h11});
        step(0, 4'b0000, 1);
        chk("r029_idle", {127'd0, obs_valid}, 128'd0);

        // Timeout issue with a late matching lane.
        t_lane[0] = 8'h05; t_lane[2] = 8'h09;
        step(0, 4'b0001, 1);
        step(0, 4'b0000, 1);
        step(0, 4'b0100, 1);
        step(0, 4'b0000, 1);
        chk("r030_early", {127'd0, obs_valid}, 128'd0);
        step(0, 4'b0000, 1);
        chk("r030_valid", {127'd0, obs_valid}, 128'd1);
        chk("r030_mask", {124'd0, obs_mask}, {124'd0, 4'b0101});
        chk("r030_tag", {120'd0, obs_tag}, {120'd0, 8'h05});
        drain();

        // Tag-mismatch conflict flush.
        t_lane[0] = 8'h01; t_lane[1] = 8'h02;
        step(0, 4'b0001, 1);
        step(0, 4'b0010, 1);
        chk("r031_block", {127'd0, obs_ready[1]}, 128'd0);
        step(0, 4'b0010, 1);
        chk("r031_mask", {124'd0, obs_mask}, {124'd0, 4'b0001});
        step(0, 4'b0010, 1);
        chk("r031_accept", {124'd0, obs_ready}, {124'd0, 4'b0010});
        drain();

        // Backpressure holds the batch stable.
        set_tags(8'h22);
        step(0, 4'b1111, 0);
        step(0, 4'b0000, 0);
        held_data = obs_data;
        step(0, 4'b1111, 0);
        step(0, 4'b0000, 0);
        chk("r032_hold", obs_data, held_data);
        chk("r032_noready", {124'd0, obs_ready}, 128'd0);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("r032_done", {127'd0, obs_valid}, 128'd0);

        // Lowest valid lane sets the tag; other lane conflicts next cycle.
        t_lane[1] = 8'h07; t_lane[3] = 8'h04;
        step(0, 4'b1010, 1);
        chk("r033_ready", {124'd0, obs_ready}, {124'd0, 4'b0010});
        step(0, 4'b1000, 1);
        step(0, 4'b1000, 1);
        chk("r033_mask", {124'd0, obs_mask}, {124'd0, 4'b0010});
        chk("r033_tag", {120'd0, obs_tag}, {120'd0, 8'h07});
        drain();

        // Reset mid-FILL discards the partial batch.
        set_tags(8'h33);
        step(0, 4'b0011, 1);
        step(1, 4'b1111, 1);
        chk("r034_rst_ready", {124'd0, obs_ready}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 4'b0000, 1);
            chk("r034_novalid", {127'd0, obs_valid}, 128'd0);
        end

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) begin
                t_lane[i] = TW'($urandom_range(0, 15));
                d_lane[i] = $urandom;
                v[i] = ($urandom_range(0, 1) == 1);
            end
            step(($urandom_range(0, 49) == 0), v, ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
